// File: rtl/bus_master_if.sv
// Master-side bus port: accepts one access from a local client, requests the
// shared bus, drives a single address-strobed cycle once granted, waits for
// slave ready (or times out), then reports completion and releases the bus.
module bus_master_if #(
    parameter int ADDR_W         = 30,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset,
    // client side
    input  logic              acc_valid,
    output logic              acc_ready,
    input  logic              acc_rw,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wr_data,
    output logic              acc_done,
    output logic              acc_err,
    output logic [DATA_W-1:0] acc_rd_data,
    // arbiter side
    output logic              m_req_,
    input  logic              m_grnt_,
    // shared bus side
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_as_,
    output logic              m_rw,
    output logic [DATA_W-1:0] m_wr_data,
    input  logic [DATA_W-1:0] s_rd_data,
    input  logic              s_rdy_
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACCESS = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    // The timeout count fits in 16 bits for every legal TIMEOUT_CYCLES value.
    localparam int              CNT_W   = 16;
    localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t              state_q;
    logic                acc_ready_q;
    logic                acc_done_q;
    logic                acc_err_q;
    logic [DATA_W-1:0]   acc_rd_data_q;
    logic                m_req_q;
    logic                m_as_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic                m_rw_q;
    logic [DATA_W-1:0]   m_wr_data_q;

    // Access captured at accept, replayed onto the bus once granted.
    logic                lat_rw_q;
    logic [ADDR_W-1:0]   lat_addr_q;
    logic [DATA_W-1:0]   lat_wr_data_q;

    logic [CNT_W-1:0]    wait_cnt_q;
    logic [CNT_W-1:0]    wait_cnt_d;
    logic                timeout_hit;

    // The last WAIT cycle before abort is the one where the counter reaches TIMEOUT_CYCLES-1.
    assign timeout_hit = TO_EN && (wait_cnt_q == TO_LAST);
    assign wait_cnt_d  = wait_cnt_q + CNT_ONE;

    // Single-process FSM: every output is a register updated here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            acc_ready_q   <= 1'b1;
            acc_done_q    <= 1'b0;
            acc_err_q     <= 1'b0;
            acc_rd_data_q <= '0;
            m_req_q       <= 1'b1;
            m_as_q        <= 1'b1;
            m_addr_q      <= '0;
            m_rw_q        <= 1'b1;
            m_wr_data_q   <= '0;
            lat_rw_q      <= 1'b1;
            lat_addr_q    <= '0;
            lat_wr_data_q <= '0;
            wait_cnt_q    <= '0;
        end else begin
            // Completion flags are single-cycle pulses.
            acc_done_q <= 1'b0;
            acc_err_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (acc_valid && acc_ready_q) begin
                        lat_rw_q      <= acc_rw;
                        lat_addr_q    <= acc_addr;
                        lat_wr_data_q <= acc_wr_data;
                        m_req_q       <= 1'b0;
                        acc_ready_q   <= 1'b0;
                        state_q       <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    // A parked grant only counts once we are actually requesting.
                    if (!m_grnt_) begin
                        m_as_q      <= 1'b0;
                        m_addr_q    <= lat_addr_q;
                        m_rw_q      <= lat_rw_q;
                        m_wr_data_q <= lat_wr_data_q;
                        state_q     <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    // Strobe lasts exactly one cycle; ready is not looked at yet.
                    m_as_q     <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (!s_rdy_) begin
                        // Ready beats a coincident timeout.
                        if (lat_rw_q) begin
                            acc_rd_data_q <= s_rd_data;
                        end
                        acc_done_q  <= 1'b1;
                        m_req_q     <= 1'b1;
                        m_addr_q    <= '0;
                        m_rw_q      <= 1'b1;
                        m_wr_data_q <= '0;
                        acc_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (timeout_hit) begin
                        acc_done_q    <= 1'b1;
                        acc_err_q     <= 1'b1;
                        acc_rd_data_q <= '0;
                        m_req_q       <= 1'b1;
                        m_addr_q      <= '0;
                        m_rw_q        <= 1'b1;
                        m_wr_data_q   <= '0;
                        acc_ready_q   <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign acc_ready   = acc_ready_q;
    assign acc_done    = acc_done_q;
    assign acc_err     = acc_err_q;
    assign acc_rd_data = acc_rd_data_q;
    assign m_req_      = m_req_q;
    assign m_as_       = m_as_q;
    assign m_addr      = m_addr_q;
    assign m_rw        = m_rw_q;
    assign m_wr_data   = m_wr_data_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Scoreboard bench for bus_master_if: a driver plays client, arbiter and slave
// with randomized timing; expected outcomes are computed from the access rules
// and queued, and an independent monitor checks them against the DUT.
module tb_bus_master_if;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          acc_valid;
    logic          acc_ready;
    logic          acc_rw;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wr_data;
    logic          acc_done;
    logic          acc_err;
    logic [DW-1:0] acc_rd_data;
    logic          m_req_;
    logic          m_grnt_;
    logic [AW-1:0] m_addr;
    logic          m_as_;
    logic          m_rw;
    logic [DW-1:0] m_wr_data;
    logic [DW-1:0] s_rd_data;
    logic          s_rdy_;

    always #5 clk = ~clk;

    bus_master_if #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .acc_valid(acc_valid),
        .acc_ready(acc_ready),
        .acc_rw(acc_rw),
        .acc_addr(acc_addr),
        .acc_wr_data(acc_wr_data),
        .acc_done(acc_done),
        .acc_err(acc_err),
        .acc_rd_data(acc_rd_data),
        .m_req_(m_req_),
        .m_grnt_(m_grnt_),
        .m_addr(m_addr),
        .m_as_(m_as_),
        .m_rw(m_rw),
        .m_wr_data(m_wr_data),
        .s_rd_data(s_rd_data),
        .s_rdy_(s_rdy_)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        logic          err;
        int            done_cyc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] model_rd = '0;
    bit            bus_on   = 1'b0;
    int            as_cnt   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Client inputs while busy: random junk that must be ignored.
    task automatic junk_acc();
        acc_valid   = 1'($urandom_range(0, 1));
        acc_rw      = 1'($urandom_range(0, 1));
        acc_addr    = AW'($urandom);
        acc_wr_data = $urandom;
    endtask

    // One access: g = cycles the grant stays high in REQ, r = WAIT cycles with ready high.
    task automatic do_txn(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int g, input int r, input logic [DW-1:0] rdata,
                          input bit rst_in_wait);
        int   waited = 0;
        int   nwait;
        exp_t e;
        @(negedge clk);
        acc_valid   = 1'b1;
        acc_rw      = rw;
        acc_addr    = addr;
        acc_wr_data = wd;
        m_grnt_     = 1'($urandom_range(0, 1));
        s_rdy_      = 1'($urandom_range(0, 1));
        s_rd_data   = $urandom;
        while (acc_ready !== 1'b1) begin
            if (waited >= 20) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_wait: acc_ready=%b, expected 1 within 20 cycles", acc_ready);
                return;
            end
            waited++;
            @(negedge clk);
        end
        // Reference outcome straight from the access rules.
        e.rw       = rw;
        e.addr     = addr;
        e.wd       = wd;
        e.err      = (r >= TO);
        nwait      = e.err ? TO : r + 1;
        e.done_cyc = cyc + 1 + 2 + g + nwait;
        e.rd       = e.err ? '0 : (rw ? rdata : model_rd);
        model_rd   = e.rd;
        exp_q.push_back(e);
        @(posedge clk);
        // REQ: grant held off for g edges
        for (int i = 0; i <= g; i++) begin
            @(negedge clk);
            junk_acc();
            m_grnt_ = (i < g);
            @(posedge clk);
        end
        // ACCESS: grant and ready are don't-cares
        @(negedge clk);
        junk_acc();
        m_grnt_   = 1'($urandom_range(0, 1));
        s_rdy_    = 1'($urandom_range(0, 1));
        s_rd_data = $urandom;
        @(posedge clk);
        if (rst_in_wait) begin
            @(negedge clk);
            junk_acc();
            s_rdy_ = 1'b1;
            @(posedge clk);
            @(negedge clk);
            #2 reset = 1'b1;
            #1;
            chk("rst_acc_ready", 64'(acc_ready), 64'(1'b1));
            chk("rst_m_req", 64'(m_req_), 64'(1'b1));
            chk("rst_m_as", 64'(m_as_), 64'(1'b1));
            chk("rst_acc_done", 64'(acc_done), 64'(1'b0));
            chk("rst_rd_data", 64'(acc_rd_data), 64'(0));
            chk("rst_m_addr", 64'(m_addr), 64'(0));
            exp_q.delete();
            model_rd  = '0;
            acc_valid = 1'b0;
            @(negedge clk);
            #2 reset = 1'b0;
            return;
        end
        // WAIT: ready high for r cycles, then low (or timeout)
        for (int j = 0; j < nwait; j++) begin
            @(negedge clk);
            junk_acc();
            m_grnt_   = 1'($urandom_range(0, 1));
            s_rdy_    = (j < r);
            s_rd_data = (j < r) ? $urandom : rdata;
            @(posedge clk);
        end
    endtask

    // Monitor: checks every cycle against the head of the expectation queue.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                bus_on = 1'b0;
                as_cnt = 0;
            end else begin
                if (acc_done) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL spurious_done: acc_done=1 with no access outstanding (cycle %0d)", cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
                        chk("acc_err", 64'(acc_err), 64'(mon_e.err));
                        chk("acc_rd_data", 64'(acc_rd_data), 64'(mon_e.rd));
                        chk("as_low_cycles", 64'(as_cnt), 64'(1));
                        chk("req_released", 64'(m_req_), 64'(1'b1));
                        chk("ready_after_done", 64'(acc_ready), 64'(1'b1));
                    end
                    bus_on = 1'b0;
                    as_cnt = 0;
                end else begin
                    chk("err_without_done", 64'(acc_err), 64'(1'b0));
                end
                if (!m_as_) begin
                    as_cnt++;
                    bus_on = 1'b1;
                end
                if (bus_on) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL bus_without_access: m_as_=%b m_addr=%0h (cycle %0d)", m_as_, m_addr, cyc);
                    end else begin
                        chk("m_addr", 64'(m_addr), 64'(exp_q[0].addr));
                        chk("m_rw", 64'(m_rw), 64'(exp_q[0].rw));
                        chk("m_wr_data", 64'(m_wr_data), 64'(exp_q[0].wd));
                        chk("m_req_held", 64'(m_req_), 64'(1'b0));
                    end
                end else begin
                    chk("idle_m_addr", 64'(m_addr), 64'(0));
                    chk("idle_m_rw", 64'(m_rw), 64'(1'b1));
                    chk("idle_m_wr_data", 64'(m_wr_data), 64'(0));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        acc_valid   = 1'b0;
        acc_rw      = 1'b0;
        acc_addr    = '0;
        acc_wr_data = '0;
        m_grnt_     = 1'b0;
        s_rdy_      = 1'b1;
        s_rd_data   = '0;
        repeat (3) @(negedge clk);
        chk("reset_acc_ready", 64'(acc_ready), 64'(1'b1));
        chk("reset_acc_done", 64'(acc_done), 64'(1'b0));
        chk("reset_acc_err", 64'(acc_err), 64'(1'b0));
        chk("reset_rd_data", 64'(acc_rd_data), 64'(0));
        chk("reset_m_req", 64'(m_req_), 64'(1'b1));
        chk("reset_m_as", 64'(m_as_), 64'(1'b1));
        chk("reset_m_addr", 64'(m_addr), 64'(0));
        chk("reset_m_rw", 64'(m_rw), 64'(1'b1));
        chk("reset_m_wr_data", 64'(m_wr_data), 64'(0));
        #2 reset = 1'b0;

        // Directed corners
        do_txn(1'b1, 30'h0000100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0);
        do_txn(1'b0, 30'h3FFFFFFF, 32'h12345678, 5, 2, 32'hCAFEF00D, 1'b0);
        do_txn(1'b1, 30'h0000ABC, 32'h0, 1, 10, 32'h11111111, 1'b0);
        do_txn(1'b1, 30'h0000ABD, 32'h0, 0, 3, 32'h22222222, 1'b0);
        do_txn(1'b0, 30'h0000ABE, 32'h33333333, 2, 4, 32'h44444444, 1'b0);
        do_txn(1'b1, 30'h0000555, 32'h0, 0, 2, 32'h55555555, 1'b1);
        do_txn(1'b1, 30'h0000666, 32'h0, 0, 1, 32'h66666666, 1'b0);

        // Randomized accesses
        for (int k = 0; k < 60; k++) begin
            do_txn(1'($urandom_range(0, 1)), AW'($urandom), $urandom,
                   int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), $urandom, 1'b0);
        end

        @(negedge clk);
        acc_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("pending_accesses", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_master_if.md
Name: bus_master_if

Overview:
- Master-side port of the shared bus: takes one access per handshake from a local client (CPU IF/MEM stage or DMA), requests the bus from the arbiter and waits for the grant.
- Once granted, it drives one address-strobed read or write, waits for slave ready, returns read data and then releases the bus.
- One instance per master m0..m3. Its m_req_/m_grnt_ pair connects to the matching mN_req_/mN_grnt_ of the round-robin arbiter.
- Includes a wait-timeout so a dead slave cannot hold the bus forever.

Parameters:
- ADDR_W, 30, word address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 256, maximum cycles in WAIT before abort. 0 disables the timeout. Legal range 0..65535.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- acc_valid  in  1  client access request.
- acc_ready  out  1  high in IDLE; access accepted on the clock edge where acc_valid & acc_ready.
- acc_rw  in  1  1 = read, 0 = write; sampled at accept.
- acc_addr  in  ADDR_W  word address; sampled at accept.
- acc_wr_data  in  DATA_W  write data; sampled at accept.
- acc_done  out  1  one-cycle pulse when the access completes or aborts.
- acc_err  out  1  one-cycle pulse together with acc_done on timeout abort.
- acc_rd_data  out  DATA_W  read data; valid while acc_done=1 and held until the next acc_done.
- m_req_  out  1  bus request to arbiter, active-low.
- m_grnt_  in  1  bus grant from arbiter, active-low.
- m_addr  out  ADDR_W  bus address.
- m_as_  out  1  address strobe, active-low.
- m_rw  out  1  bus direction, 1 = read.
- m_wr_data  out  DATA_W  bus write data.
- s_rd_data  in  DATA_W  selected slave read data.
- s_rdy_  in  1  slave ready, active-low.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, acc_ready=1, acc_done=0, acc_err=0, acc_rd_data=0, m_req_=1, m_as_=1, m_addr=0, m_rw=1, m_wr_data=0, timeout counter=0.
- Reset asserted mid-access returns everything to reset values immediately. m_req_ is released, and no acc_done is produced for the aborted access.
- IDLE:
  - acc_ready=1.
  - On accept: latch rw/addr/wr_data, m_req_<=0, go to REQ.
- REQ:
  - m_req_=0.
  - m_grnt_ is honoured only in this state. A grant low before the request (arbiter parks on master 0) has no effect until REQ.
  - On the edge where m_grnt_==0: m_as_<=0, m_addr/m_rw/m_wr_data <= latched values, go to ACCESS.
- ACCESS:
  - Exactly one cycle with m_as_=0.
  - Next edge: m_as_<=1, clear timeout counter, go to WAIT.
  - s_rdy_ is ignored in ACCESS.
- WAIT:
  - m_req_=0; addr/rw/wr_data held.
  - On the edge where s_rdy_==0: acc_rd_data<=s_rd_data (read only; write leaves acc_rd_data unchanged), acc_done<=1.
  - Same edge: m_req_<=1, bus outputs back to reset values, go to IDLE.
  - Otherwise the counter increments.
  - If TIMEOUT_CYCLES!=0 and s_rdy_ is still high on the edge where counter==TIMEOUT_CYCLES-1: acc_done<=1, acc_err<=1, acc_rd_data<=0, release bus, go to IDLE.
  - s_rdy_ low on that same edge wins: normal completion, no error.
- Bus outputs are zero (m_rw=1) outside ACCESS/WAIT, so the shared bus can be OR-muxed.
- m_grnt_ is not rechecked in ACCESS/WAIT; the arbiter holds ownership while m_req_ stays low.
- Minimum latency: accept at edge E0, grant seen at E1, ACCESS during E1–E2, ready seen at E3, acc_done high in the cycle after E3. A new accept is possible at E4.
- Since m_req_ is released for one cycle after every access, the round-robin arbiter can pass ownership between back-to-back accesses.
- acc_valid while acc_ready=0 is ignored and not queued.

Test Plan:
- Read, grant already low, slave rdy_ low one cycle after ACCESS; addr=0x0000100, s_rd_data=0xDEADBEEF -> m_as_ low exactly 1 cycle, acc_done 4 cycles after accept edge, acc_rd_data=0xDEADBEEF, m_req_ high the cycle after ready.
- Write, grant delayed 5 cycles; addr=0x3FFFFFFF, data=0x12345678 -> m_req_ low for 5 cycles before m_as_, m_rw=0, m_wr_data=0x12345678 held until ready, acc_err=0.
- TIMEOUT_CYCLES=4, slave never ready -> exactly 4 WAIT cycles, then acc_done=acc_err=1 for one cycle, acc_rd_data=0, m_req_=1 and bus outputs zero.
- TIMEOUT_CYCLES=4, s_rdy_ falls on 4th WAIT cycle -> normal completion, acc_err=0.
- Reset pulse during WAIT -> next cycle m_req_=1, m_as_=1, acc_ready=1, no acc_done. A new access then completes normally.
- acc_valid held high continuously with 4 instances on the arbiter -> acc_valid is ignored while acc_ready=0; grants rotate m0, m1, m2, m3, m0; every access completes with correct data.
